// File: rtl/obi2axi_lite.sv
// obi2axi_lite: OBI slave to AXI4-Lite master bridge with one outstanding transaction.
// Each granted OBI request becomes one AXI4-Lite read or write. The AXI response
// returns as a single-cycle rvalid_o pulse.
// Optional feature macro: OBI2AXI_ERR_EN adds err_o. It flags SLVERR/DECERR responses
// and zeroes rdata_o on a read error.
// DATA_WIDTH must be 32 or 64.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready are both
// high. A valid, once raised, holds its payload stable until that edge. No valid output
// depends combinationally on a ready input.
module obi2axi_lite #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] AXI_PROT   = 3'b000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
`ifdef OBI2AXI_ERR_EN
    output logic                    err_o,
`endif
    output logic [2:0]              dbg_state_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        READ    = 3'd3,
        RD_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  rd_err;
    logic                  wr_err;

`ifdef OBI2AXI_ERR_EN
    logic err_q;
    assign rd_err = m_axi_rresp[1];
    assign wr_err = m_axi_bresp[1];
`else
    // Responses are ignored in this build.
    logic unused_resp;
    assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;

    // Address, data and strobes come straight from the captured request.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = AXI_PROT;
    assign m_axi_arprot = AXI_PROT;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = be_q;
    assign rdata_o      = rdata_q;
    assign dbg_state_o  = state;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. AW and W may finish in either order or in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = we_i ? WRITE : READ;
            WRITE:   if ((aw_done | aw_hs) && (w_done | w_hs)) state_next = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_next = RESP;
            READ:    if (m_axi_arready) state_next = RD_RESP;
            RD_RESP: if (m_axi_rvalid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. Every valid is a function of registered state only.
    always_comb begin
        gnt_o         = (state == IDLE) & req_i;
        m_axi_awvalid = (state == WRITE) & ~aw_done;
        m_axi_wvalid  = (state == WRITE) & ~w_done;
        m_axi_bready  = (state == WR_RESP);
        m_axi_arvalid = (state == READ);
        m_axi_rready  = (state == RD_RESP);
        rvalid_o      = (state == RESP);
`ifdef OBI2AXI_ERR_EN
        err_o         = (state == RESP) & err_q;
`endif
    end

    // Capture request fields at grant. They stay stable for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state == IDLE && req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // Track completed AW/W handshakes so each valid drops on its own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WRITE) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // Response capture. Writes return zero data; read errors zero the data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (state == WR_RESP && m_axi_bvalid) begin
            rdata_q <= '0;
        end else if (state == RD_RESP && m_axi_rvalid) begin
            rdata_q <= rd_err ? '0 : m_axi_rdata;
        end
    end

`ifdef OBI2AXI_ERR_EN
    // Error flag taken from bit 1 of the response code (SLVERR/DECERR).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state == WR_RESP && m_axi_bvalid) begin
            err_q <= wr_err;
        end else if (state == RD_RESP && m_axi_rvalid) begin
            err_q <= rd_err;
        end
    end
`else
    logic unused_err;
    assign unused_err = rd_err | wr_err;
`endif

endmodule

// File: tb/tb_obi2axi_lite.sv
// tb_obi2axi_lite: directed bench for obi2axi_lite.
// A reactive AXI slave with programmable ready/response delays drives the fabric side.
// A transaction-level model checks every output on every falling edge. Per-test
// literal expectations pin latencies and field values.
module tb_obi2axi_lite;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef OBI2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic          req_i, gnt_o, we_i, rvalid_o;
  logic [AW-1:0] addr_i;
  logic [BW-1:0] be_i;
  logic [DW-1:0] wdata_i, rdata_o;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [BW-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic [2:0]    dbg_state;
  logic          err_sig;

  obi2axi_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_PROT(3'b000)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
`ifdef OBI2AXI_ERR_EN
    .err_o(err_sig),
`endif
    .dbg_state_o(dbg_state)
  );
`ifndef OBI2AXI_ERR_EN
  assign err_sig = 1'b0;
`endif

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- AXI slave (reactive driver) ----------------
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [DW-1:0] rd_data = '0;
  logic [1:0] rd_resp = 2'b00, wr_resp = 2'b00;

  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b11;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 2'b11; m_axi_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_wait >= aw_delay); aw_wait = m_axi_awready ? 0 : aw_wait + 1;
      end else begin m_axi_awready = 0; aw_wait = 0; end
      if (m_axi_wvalid) begin
        m_axi_wready = (w_wait >= w_delay); w_wait = m_axi_wready ? 0 : w_wait + 1;
      end else begin m_axi_wready = 0; w_wait = 0; end
      if (m_axi_bready) begin
        m_axi_bvalid = (b_wait >= b_delay); b_wait = m_axi_bvalid ? 0 : b_wait + 1;
      end else begin m_axi_bvalid = 0; b_wait = 0; end
      m_axi_bresp = m_axi_bvalid ? wr_resp : 2'b11;
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_wait >= ar_delay); ar_wait = m_axi_arready ? 0 : ar_wait + 1;
      end else begin m_axi_arready = 0; ar_wait = 0; end
      if (m_axi_rready) begin
        m_axi_rvalid = (r_wait >= r_delay); r_wait = m_axi_rvalid ? 0 : r_wait + 1;
      end else begin m_axi_rvalid = 0; r_wait = 0; end
      m_axi_rdata = m_axi_rvalid ? rd_data : DW'($urandom);
      m_axi_rresp = m_axi_rvalid ? rd_resp : 2'b11;
    end
  end

  // ---------------- transaction model + compare process ----------------
  // One transaction is open from the cycle after its grant until its rvalid_o cycle.
  bit            busy = 0, m_we = 0, aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [BW-1:0] m_be = '0;
  bit            m_err = 0;
  int cyc = 0;
  int grant_cyc = -1, aw_hs_cyc = -1, w_hs_cyc = -1, r_hs_cyc = -1, bready_first = -1;
  int rv_cyc = -1, rv_first = -1, rv_count = 0;
  logic [DW-1:0] last_rdata = '0, last_wdata = '0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [BW-1:0] last_wstrb = '0;
  bit last_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      busy = 0; aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
      chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_wvalid", m_axi_wvalid, 0);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_bready", m_axi_bready, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_rvalid", rvalid_o, 0);
    end else begin
      chk("gnt", gnt_o, req_i && !busy);
      chk("awvalid", m_axi_awvalid, busy && m_we && !aw_seen);
      chk("wvalid", m_axi_wvalid, busy && m_we && !w_seen);
      chk("bready", m_axi_bready, busy && m_we && aw_seen && w_seen && !b_seen);
      chk("arvalid", m_axi_arvalid, busy && !m_we && !ar_seen);
      chk("rready", m_axi_rready, busy && !m_we && ar_seen && !r_seen);
      chk("rvalid", rvalid_o, busy && (b_seen || r_seen));
      if (m_axi_awvalid) begin
        chk("awaddr", m_axi_awaddr, m_addr);
        chk("awprot", m_axi_awprot, 3'b000);
      end
      if (m_axi_wvalid) begin
        chk("wdata", m_axi_wdata, m_wdata);
        chk("wstrb", m_axi_wstrb, m_be);
      end
      if (m_axi_arvalid) begin
        chk("araddr", m_axi_araddr, m_addr);
        chk("arprot", m_axi_arprot, 3'b000);
      end
      if (rvalid_o) begin
        chk("rdata", rdata_o, m_rdata);
        if (ERR_EN) chk("err", err_sig, m_err);
      end
      if (m_axi_bready && bready_first < 0) bready_first = cyc;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_seen = 1; aw_hs_cyc = cyc; last_awaddr = m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_seen = 1; w_hs_cyc = cyc; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
      end
      if (m_axi_arvalid && m_axi_arready) begin ar_seen = 1; last_araddr = m_axi_araddr; end
      if (m_axi_bvalid && m_axi_bready) begin
        b_seen = 1; m_rdata = '0; m_err = ERR_EN && m_axi_bresp[1];
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_seen = 1; r_hs_cyc = cyc;
        m_err = ERR_EN && m_axi_rresp[1];
        m_rdata = m_err ? '0 : m_axi_rdata;
      end
      if (rvalid_o) begin
        busy = 0; rv_count++; rv_cyc = cyc;
        if (rv_first < 0) rv_first = cyc;
        last_rdata = rdata_o; last_err = err_sig;
      end
      if (req_i && gnt_o) begin
        busy = 1; m_we = we_i; m_addr = addr_i; m_wdata = wdata_i; m_be = be_i;
        aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
        grant_cyc = cyc;
      end
    end
  end

  // ---------------- OBI driver tasks ----------------
  task automatic rec_clear();
    bready_first = -1; rv_first = -1; aw_hs_cyc = -1; w_hs_cyc = -1; r_hs_cyc = -1;
  endtask

  task automatic obi_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b, input bit hold);
    int n;
    req_i = 1; we_i = we; addr_i = a; wdata_i = d; be_i = b;
    n = 0;
    @(negedge clk);
    while (!gnt_o && n < 200) begin @(negedge clk); n++; end
    if (!gnt_o) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) begin req_i = 0; addr_i = DW'($urandom); wdata_i = DW'($urandom); end
  endtask

  task automatic wait_rv(input int target);
    int n;
    n = 0;
    while (rv_count < target && n < 300) begin @(negedge clk); n++; end
    chk("rv_timeout", rv_count >= target, 1);
    @(posedge clk); #1;
  endtask

  // Global bound on run time.
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g, base;
    rst_i = 1; req_i = 0; we_i = 0; addr_i = '0; be_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_rdata_o", rdata_o, 0);
    chk("reset_awaddr", m_axi_awaddr, 0);
    chk("reset_wdata", m_axi_wdata, 0);
    chk("reset_wstrb", m_axi_wstrb, 0);
    chk("reset_gnt", gnt_o, 0);
    rst_i = 0;
    repeat (2) @(posedge clk); #1;

    // Single write, all ready immediately.
    rec_clear(); base = rv_count;
    obi_req(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0);
    g = grant_cyc;
    wait_rv(base + 1);
    chk("wr_awaddr", last_awaddr, 32'h1000_0004);
    chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", last_wstrb, 4'hF);
    chk("wr_aw_lat", aw_hs_cyc - g, 1);
    chk("wr_rv_lat", rv_cyc - g, 3);
    chk("wr_rdata", last_rdata, 0);

    // Single read, arready after 3 cycles, rvalid 2 cycles later.
    ar_delay = 3; r_delay = 2; rd_data = 32'hCAFE_F00D; rd_resp = 2'b00;
    rec_clear(); base = rv_count;
    obi_req(0, 32'h2000_0010, 32'h0, 4'h0, 0);
    g = grant_cyc;
    wait_rv(base + 1);
    chk("rd_araddr", last_araddr, 32'h2000_0010);
    chk("rd_after_r", rv_cyc - r_hs_cyc, 1);
    chk("rd_rv_lat", rv_cyc - g, 8);
    chk("rd_rdata", last_rdata, 32'hCAFE_F00D);

    // Split write handshakes: W at T1, AW at T4.
    ar_delay = 0; r_delay = 0; aw_delay = 3; w_delay = 0;
    rec_clear(); base = rv_count;
    obi_req(1, 32'h3000_0008, 32'h1234_5678, 4'h5, 0);
    g = grant_cyc;
    wait_rv(base + 1);
    chk("split_w_hs", w_hs_cyc - g, 1);
    chk("split_aw_hs", aw_hs_cyc - g, 4);
    chk("split_bready", bready_first - g, 5);
    chk("split_rv_lat", rv_cyc - g, 6);
    chk("split_rv_count", rv_count - base, 1);

    // Unaligned address and be=0 forwarded unchanged; W later than AW, slow B.
    aw_delay = 0; w_delay = 2; b_delay = 2;
    rec_clear(); base = rv_count;
    obi_req(1, 32'h0000_0003, 32'hA5A5_5A5A, 4'h0, 0);
    wait_rv(base + 1);
    chk("be0_awaddr", last_awaddr, 32'h0000_0003);
    chk("be0_wstrb", last_wstrb, 4'h0);
    w_delay = 0; b_delay = 0;

    // Back-to-back: read then write with req_i held high.
    rd_data = 32'h0BAD_F00D;
    rec_clear(); base = rv_count;
    obi_req(0, 32'h4000_0000, 32'h0, 4'h0, 1);
    obi_req(1, 32'h4000_0004, 32'h5555_AAAA, 4'hC, 0);
    g = grant_cyc;
    wait_rv(base + 2);
    chk("b2b_second_gnt", (g - rv_first) >= 1, 1);
    chk("b2b_last_rdata", last_rdata, 0);

    // Reset in the middle of a read while arvalid is high.
    ar_delay = 10;
    obi_req(0, 32'h5000_0000, 32'h0, 4'h0, 0);
    @(negedge clk);
    chk("pre_rst_arvalid", m_axi_arvalid, 1);
    #2 rst_i = 1;
    #1;
    chk("async_arvalid", m_axi_arvalid, 0);
    chk("async_rready", m_axi_rready, 0);
    chk("async_rvalid", rvalid_o, 0);
    @(negedge clk); #1 rst_i = 0;
    ar_delay = 0; r_delay = 0; rd_data = 32'h1357_9BDF;
    rec_clear(); base = rv_count;
    @(posedge clk); #1;
    obi_req(0, 32'h5000_0040, 32'h0, 4'h0, 0);
    g = grant_cyc;
    wait_rv(base + 1);
    chk("post_rst_lat", rv_cyc - g, 3);
    chk("post_rst_rdata", last_rdata, 32'h1357_9BDF);

    // Error responses: SLVERR on read, OKAY on write.
    rd_resp = 2'b10; rd_data = 32'hFFFF_0001;
    base = rv_count;
    obi_req(0, 32'h6000_0000, 32'h0, 4'h0, 0);
    wait_rv(base + 1);
    chk("err_rd_rdata", last_rdata, ERR_EN ? 32'h0 : 32'hFFFF_0001);
    chk("err_rd_flag", last_err, ERR_EN ? 1 : 0);
    rd_resp = 2'b00; wr_resp = 2'b00;
    base = rv_count;
    obi_req(1, 32'h6000_0004, 32'h2222_3333, 4'h3, 0);
    wait_rv(base + 1);
    chk("ok_wr_flag", last_err, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
